// File: rtl/riscv_pipe_chain.sv
// riscv_pipe_chain: configurable pipeline delay chain with a valid bit per
// stage, partial stall with bubble insertion, front-end flush, per-stage taps
// and a valid-stage occupancy count.
//
// Optional build macro: RISCV_PIPE_BUBBLE_ZERO_EN
//   defined   - any stage whose next valid is 0 also loads a zero payload
//   undefined - only valid bits change; bubbles keep their payload
//
// DLY_FF is a simulation-only update delay. It has no functional effect and
// is only range-checked here.
module riscv_pipe_chain #(
  parameter int DLY_FF      = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 6,
  parameter int STALL_DEPTH = 2,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall_in,
  input  logic                          flush_in,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          valid_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [DEPTH-1:0]              tap_valid_out,
  output logic [DEPTH*DATA_WIDTH-1:0]   tap_data_out,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_out
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Reject configurations outside the supported ranges at elaboration.
  if (DLY_FF < 0 || DATA_WIDTH < 1 || DATA_WIDTH > 64 ||
      DEPTH < 1 || DEPTH > 16 ||
      STALL_DEPTH < 1 || STALL_DEPTH > DEPTH ||
      FLUSH_DEPTH < 0 || FLUSH_DEPTH > DEPTH) begin : g_bad_params
    $error("riscv_pipe_chain: parameter out of range");
  end

  logic [DEPTH-1:0]      r_v;
  logic [DATA_WIDTH-1:0] r_d [DEPTH];

  // What each stage would load in a plain advance.
  logic [DEPTH-1:0]      w_v_adv;
  logic [DATA_WIDTH-1:0] w_d_adv [DEPTH];

  // Final next-state after flush / stall / bubble rules.
  logic [DEPTH-1:0]      w_v_nxt;
  logic [DATA_WIDTH-1:0] w_d_nxt [DEPTH];

  logic [OCC_W-1:0]      w_occ;

  // Advance source per stage: stage 0 takes the input, others their predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    if (k == 0) begin : g_head
      assign w_v_adv[k] = valid_in;
      assign w_d_adv[k] = data_in;
    end else begin : g_body
      assign w_v_adv[k] = r_v[k-1];
      assign w_d_adv[k] = r_d[k-1];
    end
    assign tap_data_out[k*DATA_WIDTH +: DATA_WIDTH] = r_d[k];
  end

  // Next-state selection: flush beats stall, stall beats plain advance.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_v_nxt = w_v_adv;
    w_d_nxt = w_d_adv;
    if (flush_in) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k < FLUSH_DEPTH) begin
          w_v_nxt[k] = 1'b0;
        end
      end
    end else if (stall_in) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k < STALL_DEPTH) begin
          w_v_nxt[k] = r_v[k];
          w_d_nxt[k] = r_d[k];
        end else if (k == STALL_DEPTH) begin
          // Bubble stage: only the valid bit drops, payload stays put.
          w_v_nxt[k] = 1'b0;
          w_d_nxt[k] = r_d[k];
        end
      end
    end
`ifdef RISCV_PIPE_BUBBLE_ZERO_EN
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_v_nxt[k]) begin
        w_d_nxt[k] = '0;
      end
    end
`endif
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      // NOTE: the payload array is reset as well because the outputs must
      // read zero after reset; it is a register chain, not a RAM.
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every stage samples its predecessor's
      // pre-edge value; blocking here would collapse the chain.
      r_v <= w_v_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= w_d_nxt[k];
      end
    end
  end

  // Occupancy: popcount of the registered valid bits.
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_v[k]);
    end
  end

  assign valid_out     = r_v[DEPTH-1];
  assign data_out      = r_d[DEPTH-1];
  assign tap_valid_out = r_v;
  assign occupancy_out = w_occ;

endmodule

// File: tb/tb_riscv_pipe_chain.sv
// Self-checking bench for riscv_pipe_chain (default parameters).
// Table-driven ramp, hand-written stall/flush/reset sequences, then random
// traffic against a stage-array reference model.
module tb_riscv_pipe_chain;

  localparam int DW    = 32;
  localparam int DEPTH = 6;
  localparam int STALL = 2;
  localparam int FLUSH = 3;
`ifdef RISCV_PIPE_BUBBLE_ZERO_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic                  stall_in;
  logic                  flush_in;
  logic                  valid_in;
  logic [DW-1:0]         data_in;
  logic                  valid_out;
  logic [DW-1:0]         data_out;
  logic [DEPTH-1:0]      tap_valid_out;
  logic [DEPTH*DW-1:0]   tap_data_out;
  logic [2:0]            occupancy_out;

  riscv_pipe_chain #(
    .DLY_FF(1), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .STALL_DEPTH(STALL), .FLUSH_DEPTH(FLUSH)
  ) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out),
    .data_out(data_out), .tap_valid_out(tap_valid_out),
    .tap_data_out(tap_data_out), .occupancy_out(occupancy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one slot per stage.
  bit            m_v [DEPTH];
  logic [DW-1:0] m_d [DEPTH];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic s,
                            input logic v, input logic [DW-1:0] d);
    bit            nv [DEPTH];
    logic [DW-1:0] nd [DEPTH];
    if (r) begin
      for (int k = 0; k < DEPTH; k++) begin m_v[k] = 0; m_d[k] = '0; end
      return;
    end
    for (int k = DEPTH-1; k > 0; k--) begin nv[k] = m_v[k-1]; nd[k] = m_d[k-1]; end
    nv[0] = v; nd[0] = d;
    if (f) begin
      for (int k = 0; k < FLUSH; k++) nv[k] = 0;
    end else if (s) begin
      for (int k = 0; k < STALL; k++) begin nv[k] = m_v[k]; nd[k] = m_d[k]; end
      if (STALL < DEPTH) begin nv[STALL] = 0; nd[STALL] = m_d[STALL]; end
    end
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = nv[k];
      m_d[k] = (ZERO && !nv[k]) ? '0 : nd[k];
    end
  endtask

  task automatic tick(input logic r, input logic f, input logic s,
                      input logic v, input logic [DW-1:0] d);
    reset = r; flush_in = f; stall_in = s; valid_in = v; data_in = d;
    @(posedge clk);
    model_step(r, f, s, v, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [DEPTH-1:0]    ev;
    logic [DEPTH*DW-1:0] ed;
    int                  occ;
    occ = 0;
    for (int k = 0; k < DEPTH; k++) begin
      ev[k] = m_v[k];
      ed[k*DW +: DW] = m_d[k];
      occ += int'(m_v[k]);
    end
    check({tag, " valid_out"}, valid_out, m_v[DEPTH-1]);
    check({tag, " data_out"}, data_out, m_d[DEPTH-1]);
    check({tag, " tap_valid"}, tap_valid_out, ev);
    check({tag, " tap_data"}, tap_data_out, ed);
    check({tag, " occupancy"}, occupancy_out, occ);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 1, base + DW'(i));
  endtask

  function automatic logic [DW-1:0] stage_d(input int k);
    return tap_data_out[k*DW +: DW];
  endfunction

  typedef struct {
    logic          rst;
    logic          flush;
    logic          stall;
    logic          vin;
    logic [DW-1:0] din;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [2:0]    exp_occ;
  } vec_t;

  vec_t vecs [13];

  initial begin
    reset = 1'b1; stall_in = 0; flush_in = 0; valid_in = 0; data_in = '0;

    // ---- table: reset, then a 12-cycle valid ramp 0x10, 0x11, ...
    vecs[0] = '{rst: 1, flush: 0, stall: 0, vin: 0, din: '0, exp_v: 0, exp_d: '0, exp_occ: 0};
    for (int i = 0; i < 12; i++) begin
      vecs[i+1].rst     = 0;
      vecs[i+1].flush   = 0;
      vecs[i+1].stall   = 0;
      vecs[i+1].vin     = 1;
      vecs[i+1].din     = 32'h10 + DW'(i);
      vecs[i+1].exp_v   = (i >= DEPTH-1);
      vecs[i+1].exp_d   = (i >= DEPTH-1) ? 32'h10 + DW'(i - (DEPTH-1)) : '0;
      vecs[i+1].exp_occ = (i >= DEPTH-1) ? 3'(DEPTH) : 3'(i + 1);
    end
    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].vin, vecs[i].din);
      check($sformatf("vec%0d valid_out", i), valid_out, vecs[i].exp_v);
      check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_d);
      check($sformatf("vec%0d occupancy", i), occupancy_out, vecs[i].exp_occ);
      if (i == 0) begin
        check("reset tap_valid", tap_valid_out, '0);
        check("reset tap_data", tap_data_out, '0);
      end
    end

    // ---- stall for two cycles on a full chain A0..A5
    fill(32'hA0);
    check("fill tap_valid", tap_valid_out, 6'b111111);
    tick(0, 0, 1, 1, 32'hA6);
    check("stall1 tap_valid", tap_valid_out, 6'b111011);
    check("stall1 occupancy", occupancy_out, 5);
    tick(0, 0, 1, 1, 32'hA6);
    check("stall2 tap_valid", tap_valid_out, 6'b110011);
    check("stall2 occupancy", occupancy_out, 4);
    check("stall2 st0 held", stage_d(0), 32'hA5);
    check("stall2 st1 held", stage_d(1), 32'hA4);
    check("stall2 bubble payload", stage_d(2), ZERO ? 32'h0 : 32'hA3);
    check("stall2 data_out", data_out, 32'hA2);
    tick(0, 0, 0, 1, 32'hA6);
    check("rel1 valid_out", valid_out, 1'b1);
    check("rel1 data_out", data_out, 32'hA3);
    tick(0, 0, 0, 1, 32'hA7);
    check("rel2 valid_out", valid_out, 1'b0);
    tick(0, 0, 0, 1, 32'hA8);
    check("rel3 valid_out", valid_out, 1'b0);
    tick(0, 0, 0, 1, 32'hA9);
    check("rel4 valid_out", valid_out, 1'b1);
    check("rel4 data_out", data_out, 32'hA4);

    // ---- single-cycle flush on a full chain
    fill(32'hA0);
    tick(0, 1, 0, 1, 32'hB0);
    check("flush tap_valid", tap_valid_out, 6'b111000);
    check("flush occupancy", occupancy_out, 3);
    check("flush st0 payload", stage_d(0), ZERO ? 32'h0 : 32'hB0);
    check("flush data_out", data_out, 32'hA1);
    tick(0, 0, 0, 0, '0);
    check("retire1 data_out", data_out, 32'hA2);
    check("retire1 valid_out", valid_out, 1'b1);
    tick(0, 0, 0, 0, '0);
    check("retire2 data_out", data_out, 32'hA3);
    check("retire2 valid_out", valid_out, 1'b1);
    tick(0, 0, 0, 0, '0);
    check("retire3 valid_out", valid_out, 1'b0);

    // ---- flush and stall together behave as flush alone
    fill(32'hA0);
    tick(0, 1, 1, 1, 32'hC0);
    check("flush+stall tap_valid", tap_valid_out, 6'b111000);
    check("flush+stall st0 payload", stage_d(0), ZERO ? 32'h0 : 32'hC0);
    check("flush+stall st1 advanced", stage_d(1), ZERO ? 32'h0 : 32'hA5);
    check("flush+stall st3 advanced", stage_d(3), 32'hA3);

    // ---- reset mid-stream, then resume
    fill(32'hA0);
    tick(1, 0, 0, 1, 32'hAA);
    check("midreset valid_out", valid_out, 1'b0);
    check("midreset data_out", data_out, '0);
    check("midreset tap_valid", tap_valid_out, '0);
    check("midreset tap_data", tap_data_out, '0);
    check("midreset occupancy", occupancy_out, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      tick(0, 0, 0, 1, 32'hD0 + DW'(i - 1));
      check($sformatf("resume%0d valid_out", i), valid_out, (i == DEPTH));
    end
    check("resume data_out", data_out, 32'hD0);

    // ---- randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      logic r, f, s, v;
      r = ($urandom_range(63) == 0);
      f = ($urandom_range(7) == 0);
      s = ($urandom_range(4) == 0);
      v = ($urandom_range(3) != 0);
      tick(r, f, s, v, $urandom);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
